// File: rtl/dadda_mac_ctrl.sv
// Streaming 8x8 multiply-accumulate controller: a carry-save reduction tree
// with the accumulator as addend, a 17-bit final add and a valid/ready front/back end.
module dadda_mac_ctrl #(
  parameter int LEN_W = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_acc,
  output logic             out_ovf,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // 3:2 compressor on 17-bit rows; returns {sum_row, carry_row}
  function automatic logic [33:0] csa3(input logic [16:0] x,
                                       input logic [16:0] y,
                                       input logic [16:0] z);
    logic [16:0] s_s;
    logic [16:0] maj_s;
    s_s   = x ^ y ^ z;
    maj_s = (x & y) | (x & z) | (y & z);
    return {s_s, {maj_s[15:0], 1'b0}};
  endfunction

  // Reduces 8 partial-product rows plus the addend to two rows (9->6->4->3->2).
  // Carries past bit 16 are dropped; a*b+m always fits in 17 bits.
  function automatic logic [33:0] dadda_tree(input logic [7:0]  a,
                                             input logic [7:0]  b,
                                             input logic [15:0] m);
    logic [16:0] pp [0:8];
    logic [33:0] l1a, l1b, l1c, l2a, l2b, l3;
    for (int i = 0; i < 8; i++) begin
      pp[i] = b[i] ? ({9'd0, a} << i) : 17'd0;
    end
    pp[8] = {1'b0, m};
    l1a = csa3(pp[0], pp[1], pp[2]);
    l1b = csa3(pp[3], pp[4], pp[5]);
    l1c = csa3(pp[6], pp[7], pp[8]);
    l2a = csa3(l1a[33:17], l1a[16:0], l1b[33:17]);
    l2b = csa3(l1b[16:0], l1c[33:17], l1c[16:0]);
    l3  = csa3(l2a[33:17], l2a[16:0], l2b[33:17]);
    return csa3(l3[33:17], l3[16:0], l2b[16:0]);
  endfunction

  state_t           state_r;
  logic [15:0]      acc_r;
  logic             ovf_r;
  logic [LEN_W-1:0] cnt_r;
  logic             s_v_r;
  logic [7:0]       a_q_r;
  logic [7:0]       b_q_r;
  logic             busy_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             done_r;

  logic [33:0]      mac_s;
  logic [16:0]      r17_s;
  logic [15:0]      acc_next_s;

  // Tree, final carry-propagate add and optional saturation
  always_comb begin
    mac_s = dadda_tree(a_q_r, b_q_r, acc_r);
    r17_s = mac_s[33:17] + mac_s[16:0];
    if (SAT && r17_s[16]) begin
      acc_next_s = 16'hFFFF;
    end else begin
      acc_next_s = r17_s[15:0];
    end
  end

  // Command FSM, operand stage, accumulator and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= 16'd0;
      ovf_r       <= 1'b0;
      cnt_r       <= {LEN_W{1'b0}};
      s_v_r       <= 1'b0;
      a_q_r       <= 8'd0;
      b_q_r       <= 8'd0;
      busy_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      s_v_r  <= 1'b0;
      if (s_v_r) begin
        acc_r <= acc_next_s;
        ovf_r <= ovf_r | r17_s[16];
      end else begin
        acc_r <= acc_r;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r  <= 16'd0;
            ovf_r  <= 1'b0;
            busy_r <= 1'b1;
            if (len != {LEN_W{1'b0}}) begin
              cnt_r      <= len;
              state_r    <= RUN;
              in_ready_r <= 1'b1;
            end else begin
              state_r     <= OUT;
              out_valid_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (in_valid && in_ready_r) begin
            a_q_r <= in_a;
            b_q_r <= in_b;
            s_v_r <= 1'b1;
            cnt_r <= cnt_r - LEN_W'(1);
            if (cnt_r == LEN_W'(1)) begin
              state_r    <= DRAIN;
              in_ready_r <= 1'b0;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          state_r     <= OUT;
          out_valid_r <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end else begin
            state_r <= OUT;
          end
        end
        default: begin
          state_r     <= IDLE;
          busy_r      <= 1'b0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_acc   = acc_r;
  assign out_ovf   = ovf_r;
  assign done      = done_r;

endmodule

// File: doc/dadda_mac_ctrl.md
# dadda_mac_ctrl

Sequencing controller that turns the combinational 8x8 Dadda reduction tree (`processing_block`) into a streaming multiply-accumulate engine. It accepts a start command with a vector length, takes one operand pair per cycle over a valid/ready handshake, and forms each pair's partial-product matrix. It feeds the running accumulator into the tree's addend input, resolves the tree's sum/carry rows with a final carry-propagate add, and presents the dot-product result on an output handshake.

## Interface
- `LEN_W`, 8: width of the vector-length field; maximum vector length 2^LEN_W − 1.
- `SAT`, 0: 0 = accumulator wraps modulo 2^16; 1 = accumulator saturates at 16'hFFFF.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `len`  in  LEN_W  number of operand pairs; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller accepts a pair this cycle.
- `in_a`  in  8  unsigned multiplicand.
- `in_b`  in  8  unsigned multiplier.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `out_acc`  out  16  accumulated result.
- `out_ovf`  out  1  sticky overflow flag for this command.
- `done`  out  1  one-cycle pulse on the cycle after the result is taken.

## Operation
- Partial products are formed from the stage register: P[i][j] = a_q[j] & b_q[i].
- Tree addend M = acc. Tree contract: MAC[0] + MAC[1] = a_q*b_q + acc, 17 bits.
- CPA: r17 = MAC[0] + MAC[1], zero-extended to 17 bits.
- Accumulate update:
  - SAT=0: acc ← r17[15:0].
  - SAT=1: acc ← r17[16] ? 16'hFFFF : r17[15:0].
  - In both modes ovf ← ovf | r17[16].
- States:
  - IDLE: `in_ready`=0. On `start` with `len`≠0: acc←0, ovf←0, cnt←len, go to RUN. On `start` with `len`=0: acc←0, ovf←0, go to OUT.
  - RUN: `in_ready`=1. Each handshake (`in_valid`&`in_ready`) loads a_q/b_q, sets s_v, and decrements cnt. The handshake that brings cnt to 0 moves the FSM to DRAIN.
  - DRAIN: `in_ready`=0. The final pending accumulate completes; go to OUT.
  - OUT: `out_valid`=1; `out_acc`=acc and `out_ovf`=ovf, held stable. On `out_ready`, go to IDLE and assert `done` for the following cycle.
- Pending product: whenever s_v=1, the accumulate executes at the next edge and s_v clears unless a new handshake reloads it the same cycle. Back-to-back pairs therefore accumulate at full rate.
- `start` is ignored outside IDLE; `len` is not re-sampled mid-command.
- `in_valid` outside RUN is ignored; no pair is consumed.

## Timing
- Reset values: state=IDLE, acc=0, ovf=0, cnt=0, s_v=0, a_q=b_q=0. Outputs: `busy`=0, `in_ready`=0, `out_valid`=0, `out_acc`=0, `out_ovf`=0, `done`=0.
- `in_ready`, `busy` and `out_valid` are decoded from registered state only; there is no combinational path from inputs.
- A pair accepted at edge k is reflected in acc at edge k+1.
- Start to first `in_ready`: 1 cycle.
- Last accepted pair to `out_valid`: 2 cycles (DRAIN, then OUT).
- Throughput: 1 pair/cycle while `in_valid` stays high.
- `in_valid` low in RUN: stall, no count change; the pending product still completes.
- `out_ready` low: OUT holds indefinitely and the result stays stable.
- `out_ready` high on the first OUT cycle: IDLE on the next edge; `done` high in that IDLE cycle. A `start` in that same cycle is accepted.
- `rst` asserted in any state (including mid-RUN with s_v=1): all state returns to reset values at that edge. The pending product is discarded, and no `done` or `out_valid` is generated.
- Critical path: a_q/b_q/acc → tree → 17-bit CPA → saturation mux → acc, within one cycle.

## Test plan
- Single pair: len=1, (255,255) → `out_acc`=16'hFE01, `out_ovf`=0, `out_valid` 2 cycles after the handshake, then `done` pulse.
- Dot product: len=3, (10,20),(3,4),(255,1) back-to-back → `out_acc`=16'h01D3, `out_ovf`=0, `in_ready` high for exactly 3 cycles.
- Overflow: len=2, (255,255)×2 (sum 17'h1FC02):
  - SAT=0 → `out_acc`=16'hFC02, `out_ovf`=1.
  - SAT=1 → `out_acc`=16'hFFFF, `out_ovf`=1.
- Zero length: `start` with len=0 → OUT on the next cycle with `out_acc`=0, `out_ovf`=0; no `in_ready`.
- Backpressure: len=4, `in_valid` toggling 1,0,1,0… and `out_ready` held low for 5 cycles → result correct (for pairs (2,3)×4: 16'h0018) and stable throughout the stall; `start` during the stall is ignored.
- Reset mid-command: `rst` after 2 of 4 pairs → all outputs 0 next cycle. A new len=1, (7,6) command afterwards → `out_acc`=16'h002A, `out_ovf`=0.
